riscv_muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit used as a multi-cycle side unit of the EXE stage.

---
 rtl/riscv_muldiv_unit.sv | 205 ++++++++++++++++++++
 tb/tb_riscv_muldiv_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M multiply/divide side unit: radix-2^MUL_STEP shift-add multiply,
// restoring radix-2 divide, single-cycle fast path for divide-by-zero and signed overflow.
module riscv_muldiv_unit #(
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 5,
  parameter int MUL_STEP = 2
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] rs1,
  input  logic [DATA_W-1:0] rs2,
  input  logic [TAG_W-1:0]  rd_tag,
  input  logic              kill,
  output logic              busy,
  output logic              stall_req,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [TAG_W-1:0]  rd_out
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(DATA_W / MUL_STEP - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [DATA_W-1:0] ZERO_W  = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] ONES_W  = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              state_r;
  logic [2:0]          op_r;
  logic [TAG_W-1:0]    tag_r;
  logic [DATA_W-1:0]   hi_r, lo_r, opnd_r;
  logic                sa_r, sb_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [DATA_W-1:0]   result_r;
  logic [TAG_W-1:0]    rd_out_r;
  logic                done_r;

  logic                sgn_a_s, sgn_b_s, div_zero_s, ovf_s, div_ok_s;
  logic [DATA_W-1:0]   abs_a_s, abs_b_s, div_rem_s, quo_fix_s, rem_fix_s, fix_res_s;
  logic [DATA_W:0]     div_shift_s;
  logic [DATA_W+MUL_STEP-1:0] mul_sum_s;
  logic [2*DATA_W-1:0] mul_next_s, prod_fix_s;

  function automatic logic [DATA_W+MUL_STEP-1:0] partial_prod(
    input logic [DATA_W-1:0]   a,
    input logic [MUL_STEP-1:0] d
  );
    logic [DATA_W+MUL_STEP-1:0] pp;
    pp = {(DATA_W+MUL_STEP){1'b0}};
    for (int i = 0; i < MUL_STEP; i++) begin
      if (d[i]) pp = pp + ({{MUL_STEP{1'b0}}, a} << i);
      else      pp = pp;
    end
    return pp;
  endfunction

  // Operand sign flags: MULHSU treats only rs1 as signed, unsigned ops ignore signs.
  always_comb begin
    sgn_a_s = 1'b0;
    sgn_b_s = 1'b0;
    case (op)
      3'd1, 3'd4, 3'd6: begin
        sgn_a_s = rs1[DATA_W-1];
        sgn_b_s = rs2[DATA_W-1];
      end
      3'd2:    sgn_a_s = rs1[DATA_W-1];
      default: begin
        sgn_a_s = 1'b0;
        sgn_b_s = 1'b0;
      end
    endcase
  end

  assign abs_a_s    = sgn_a_s ? -rs1 : rs1;
  assign abs_b_s    = sgn_b_s ? -rs2 : rs2;
  assign div_zero_s = (rs2 == ZERO_W);
  assign ovf_s      = ((op == 3'd4) || (op == 3'd6)) && (rs1 == MIN_NEG) && (rs2 == ONES_W);

  // Multiply: hi accumulates, lo holds the unretired multiplier bits and collects product bits.
  assign mul_sum_s  = {{MUL_STEP{1'b0}}, hi_r} + partial_prod(opnd_r, lo_r[MUL_STEP-1:0]);
  assign mul_next_s = {mul_sum_s, lo_r[DATA_W-1:MUL_STEP]};

  // Divide: hi is the partial remainder, lo shifts the dividend out and the quotient in.
  assign div_shift_s = {hi_r, lo_r[DATA_W-1]};
  assign div_ok_s    = (div_shift_s >= {1'b0, opnd_r});
  assign div_rem_s   = div_shift_s[DATA_W-1:0] - opnd_r;

  assign prod_fix_s = (sa_r ^ sb_r) ? -{hi_r, lo_r} : {hi_r, lo_r};
  assign quo_fix_s  = (sa_r ^ sb_r) ? -lo_r : lo_r;
  assign rem_fix_s  = sa_r ? -hi_r : hi_r;

  // Final result selection by operation.
  always_comb begin
    fix_res_s = ZERO_W;
    case (op_r)
      3'd0:                   fix_res_s = prod_fix_s[DATA_W-1:0];
      3'd1, 3'd2, 3'd3:       fix_res_s = prod_fix_s[2*DATA_W-1:DATA_W];
      3'd4, 3'd5:             fix_res_s = quo_fix_s;
      3'd6, 3'd7:             fix_res_s = rem_fix_s;
      default:                fix_res_s = ZERO_W;
    endcase
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r  <= S_IDLE;
      op_r     <= 3'd0;
      tag_r    <= {TAG_W{1'b0}};
      hi_r     <= ZERO_W;
      lo_r     <= ZERO_W;
      opnd_r   <= ZERO_W;
      sa_r     <= 1'b0;
      sb_r     <= 1'b0;
      cnt_r    <= CNT_ZERO;
      result_r <= ZERO_W;
      rd_out_r <= {TAG_W{1'b0}};
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start && !kill) begin
            op_r  <= op;
            tag_r <= rd_tag;
            if (!op[2]) begin
              opnd_r  <= abs_a_s;
              lo_r    <= abs_b_s;
              hi_r    <= ZERO_W;
              sa_r    <= sgn_a_s;
              sb_r    <= sgn_b_s;
              cnt_r   <= MUL_LAST;
              state_r <= S_MUL;
            end else if (!div_zero_s && !ovf_s) begin
              opnd_r  <= abs_b_s;
              lo_r    <= abs_a_s;
              hi_r    <= ZERO_W;
              sa_r    <= sgn_a_s;
              sb_r    <= sgn_b_s;
              cnt_r   <= DIV_LAST;
              state_r <= S_DIV;
            end else begin
              // Fast path: preload the architectural answer as an unsigned quotient/remainder.
              lo_r    <= div_zero_s ? ONES_W : rs1;
              hi_r    <= div_zero_s ? rs1 : ZERO_W;
              sa_r    <= 1'b0;
              sb_r    <= 1'b0;
              state_r <= S_FIX;
            end
          end
        end
        S_MUL: begin
          if (kill) begin
            state_r <= S_IDLE;
          end else begin
            {hi_r, lo_r} <= mul_next_s;
            cnt_r        <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_ZERO) state_r <= S_FIX;
          end
        end
        S_DIV: begin
          if (kill) begin
            state_r <= S_IDLE;
          end else begin
            hi_r  <= div_ok_s ? div_rem_s : div_shift_s[DATA_W-1:0];
            lo_r  <= {lo_r[DATA_W-2:0], div_ok_s};
            cnt_r <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_ZERO) state_r <= S_FIX;
          end
        end
        S_FIX: begin
          if (kill) begin
            state_r <= S_IDLE;
          end else begin
            result_r <= fix_res_s;
            rd_out_r <= tag_r;
            done_r   <= 1'b1;
            state_r  <= S_DONE;
          end
        end
        S_DONE:  state_r <= S_IDLE;
        default: state_r <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state_r == S_MUL) || (state_r == S_DIV) || (state_r == S_FIX);
  assign stall_req = (start && !kill && (state_r == S_IDLE)) || busy;
  assign done      = done_r;
  assign result    = result_r;
  assign rd_out    = rd_out_r;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Directed self-checking bench for riscv_muldiv_unit (DATA_W=32, MUL_STEP=2).
module tb_riscv_muldiv_unit;

  logic        clk = 1'b0;
  logic        nrst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd_tag;
  logic        kill;
  logic        busy, stall_req, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_checks = 0;
  int n_fail   = 0;

  riscv_muldiv_unit #(.DATA_W(32), .TAG_W(5), .MUL_STEP(2)) dut (
    .clk(clk), .nrst(nrst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .rd_tag(rd_tag), .kill(kill), .busy(busy), .stall_req(stall_req),
    .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, count edges to done, check latency, result, tag and stall behaviour.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] t,
                        input logic [31:0] exp_res, input int exp_lat, input bit poke);
    int n;
    bit stall_ok;
    @(negedge clk);
    op = o; rs1 = a; rs2 = b; rd_tag = t; start = 1'b1;
    #1 check_val({tag, "_stall_start"}, 64'(stall_req), 64'd1);
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    stall_ok = 1'b1;
    while (n < 100) begin
      n++;
      if (poke && n == 3) begin
        start = 1'b1; op = 3'd4; rs1 = 32'd99; rs2 = 32'd3; rd_tag = 5'd31;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done) break;
      if (!stall_req) stall_ok = 1'b0;
    end
    start = 1'b0;
    check_val({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check_val({tag, "_result"}, 64'(result), 64'(exp_res));
    check_val({tag, "_rd_out"}, 64'(rd_out), 64'(t));
    check_val({tag, "_stall_done"}, 64'(stall_req), 64'd0);
    if (exp_lat > 1) check_val({tag, "_stall_held"}, 64'(stall_ok), 64'd1);
    @(posedge clk);
    #1 check_val({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  // Watch a window of cycles and require that done never rises.
  task automatic expect_no_done(input string tag, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1 if (done) seen = 1'b1;
    end
    check_val({tag, "_no_done"}, 64'(seen), 64'd0);
  endtask

  initial begin
    nrst = 1'b0; start = 1'b0; kill = 1'b0; op = 3'd0;
    rs1 = 32'd0; rs2 = 32'd0; rd_tag = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_busy",   64'(busy),      64'd0);
    check_val("rst_done",   64'(done),      64'd0);
    check_val("rst_result", 64'(result),    64'd0);
    check_val("rst_rd_out", 64'(rd_out),    64'd0);
    check_val("rst_stall",  64'(stall_req), 64'd0);
    @(negedge clk) nrst = 1'b1;

    run_op("mul",    3'd0, 32'd7,        32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 17, 1'b1);
    run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 17, 1'b0);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 17, 1'b0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2,         5'd3, 32'hFFFF_FFFF, 17, 1'b0);
    run_op("divu",   3'd5, 32'd100,       32'd7,         5'd4, 32'd14,        33, 1'b0);
    run_op("rem",    3'd6, 32'hFFFF_FF9C, 32'd7,         5'd6, 32'hFFFF_FFFE, 33, 1'b0);
    run_op("div",    3'd4, 32'hFFFF_FF9C, 32'd7,         5'd8, 32'hFFFF_FFF2, 33, 1'b0);

    // Kill a DIVU in flight: no done, outputs keep the previous result and tag.
    @(negedge clk);
    op = 3'd5; rs1 = 32'd1000; rs2 = 32'd3; rd_tag = 5'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 check_val("kill_busy_before", 64'(busy), 64'd1);
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    check_val("kill_busy_after", 64'(busy),   64'd0);
    check_val("kill_done",       64'(done),   64'd0);
    check_val("kill_result",     64'(result), 64'hFFFF_FFF2);
    check_val("kill_rd_out",     64'(rd_out), 64'd8);
    expect_no_done("kill", 40);
    run_op("mul_after_kill", 3'd0, 32'd3, 32'd4, 5'd10, 32'd12, 17, 1'b0);

    run_op("div_by0",   3'd4, 32'h0000_1234, 32'd0,         5'd11, 32'hFFFF_FFFF, 1, 1'b0);
    run_op("remu_by0",  3'd7, 32'h0000_1234, 32'd0,         5'd12, 32'h0000_1234, 1, 1'b0);
    run_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1, 1'b0);
    run_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0,         1, 1'b0);
    run_op("rem_neg0",  3'd6, 32'hFFFF_FF9C, 32'd0,         5'd15, 32'hFFFF_FF9C, 1, 1'b0);

    // kill together with start in IDLE: nothing starts.
    @(negedge clk);
    op = 3'd5; rs1 = 32'd8; rs2 = 32'd2; rd_tag = 5'd16; start = 1'b1; kill = 1'b1;
    #1 check_val("kill_start_stall", 64'(stall_req), 64'd0);
    @(posedge clk);
    #1 start = 1'b0; kill = 1'b0;
    check_val("kill_start_busy", 64'(busy), 64'd0);
    expect_no_done("kill_start", 40);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    op = 3'd5; rs1 = 32'd500; rs2 = 32'd9; rd_tag = 5'd17; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #3 nrst = 1'b0;
    #1;
    check_val("arst_result", 64'(result),    64'd0);
    check_val("arst_rd_out", 64'(rd_out),    64'd0);
    check_val("arst_busy",   64'(busy),      64'd0);
    check_val("arst_done",   64'(done),      64'd0);
    check_val("arst_stall",  64'(stall_req), 64'd0);
    @(negedge clk) nrst = 1'b1;
    expect_no_done("arst", 40);
    run_op("divu_after_rst", 3'd5, 32'd100, 32'd7, 5'd7, 32'd14, 33, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
